connect4_turn_sequencer: RTL and testbench

Per-turn game controller for the Connect4 datapath. It selects the active move source for the current player (FPGA buttons or Arduino SPI receiver) and validates the requested column against per-column fill heights. It issues a single-cycle write strobe with column, row and cell value to the board register array, then evaluates the victory checker's result and switches turns. It also runs the per-turn countdown, auto-plays on timeout and reports game-over, winner and draw.

---
 rtl/connect4_turn_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_connect4_turn_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_turn_sequencer.sv
// Connect4 per-turn controller: picks the active move source, validates the column against
// the fill heights, strobes the board write, runs the turn countdown and reports the result.
module connect4_turn_sequencer #(
    parameter int CLK_HZ    = 50000000,
    parameter int TURN_SECS = 10,
    parameter int ROWS      = 6,
    parameter int COLS      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_player,
    input  logic       fpga_load,
    input  logic [2:0] fpga_col,
    input  logic       ard_valid,
    input  logic [2:0] ard_col,
    input  logic       win,
    output logic       write_en,
    output logic [2:0] write_col,
    output logic [2:0] write_row,
    output logic [1:0] write_val,
    output logic       current_player,
    output logic [3:0] secs_left,
    output logic       reject,
    output logic [5:0] move_count,
    output logic       board_full,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int CELLS = ROWS * COLS;
    localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_MOVE = 3'd1,
        CHECK     = 3'd2,
        WRITE     = 3'd3,
        EVAL      = 3'd4,
        SWITCH    = 3'd5,
        OVER      = 3'd6
    } state_t;

    state_t        state_r;
    state_t        next_state_s;

    logic          player_r;
    logic [2:0]    col_r;
    logic [2:0]    height_r [COLS];
    logic [PW-1:0] prescale_r;
    logic [3:0]    secs_r;
    logic [5:0]    move_count_r;
    logic          board_full_r;
    logic          game_over_r;
    logic [1:0]    winner_r;
    logic          write_en_r;
    logic [2:0]    write_col_r;
    logic [2:0]    write_row_r;
    logic [1:0]    write_val_r;
    logic          reject_r;

    logic          move_req_s;
    logic [2:0]    move_col_s;
    logic          timeout_s;
    logic [2:0]    auto_col_s;
    logic [2:0]    sel_height_s;
    logic          col_in_range_s;
    logic          bad_move_s;

    function automatic logic [1:0] cell_code(input logic player);
        return player ? 2'b10 : 2'b01;
    endfunction

    // Source select for the current player, plus column lookup and auto-move choice.
    always_comb begin
        move_req_s   = 1'b0;
        move_col_s   = 3'd0;
        auto_col_s   = 3'd0;
        sel_height_s = 3'd0;
        if (player_r) begin
            move_req_s = ard_valid;
            move_col_s = ard_col;
        end else begin
            move_req_s = fpga_load;
            move_col_s = fpga_col;
        end
        // Descending scan so the lowest-index non-full column is the one left standing.
        for (int c = COLS - 1; c >= 0; c--) begin
            auto_col_s   = (height_r[c] == 3'(ROWS)) ? auto_col_s : 3'(c);
            sel_height_s = (col_r == 3'(c)) ? height_r[c] : sel_height_s;
        end
        timeout_s      = (secs_r == 4'd0);
        col_in_range_s = (int'(col_r) < COLS);
        bad_move_s     = !col_in_range_s || (sel_height_s == 3'(ROWS));
    end

    // Next-state logic of the turn FSM.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:      next_state_s = WAIT_MOVE;
            WAIT_MOVE: begin
                if (move_req_s || timeout_s) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = WAIT_MOVE;
                end
            end
            CHECK:     next_state_s = bad_move_s ? WAIT_MOVE : WRITE;
            WRITE:     next_state_s = EVAL;
            EVAL: begin
                if (win || (move_count_r == 6'(CELLS))) begin
                    next_state_s = OVER;
                end else begin
                    next_state_s = SWITCH;
                end
            end
            SWITCH:    next_state_s = WAIT_MOVE;
            OVER:      next_state_s = OVER;
            default:   next_state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Turn datapath: move latch, countdown, write strobe, fill heights and result flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_r     <= 1'b0;
            col_r        <= 3'd0;
            prescale_r   <= {PW{1'b0}};
            secs_r       <= 4'(TURN_SECS);
            move_count_r <= 6'd0;
            board_full_r <= 1'b0;
            game_over_r  <= 1'b0;
            winner_r     <= 2'b00;
            write_en_r   <= 1'b0;
            write_col_r  <= 3'd0;
            write_row_r  <= 3'd0;
            write_val_r  <= 2'b00;
            reject_r     <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                height_r[c] <= 3'd0;
            end
        end else begin
            write_en_r <= 1'b0;
            reject_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    player_r <= start_player;
                end
                WAIT_MOVE: begin
                    // A real move beats a timeout that lands in the same cycle.
                    if (move_req_s) begin
                        col_r <= move_col_s;
                    end else if (timeout_s) begin
                        col_r <= auto_col_s;
                    end
                    if (!timeout_s) begin
                        if (prescale_r == PW'(CLK_HZ - 1)) begin
                            prescale_r <= {PW{1'b0}};
                            secs_r     <= secs_r - 4'd1;
                        end else begin
                            prescale_r <= prescale_r + PW'(1);
                        end
                    end
                end
                CHECK: begin
                    if (bad_move_s) begin
                        reject_r <= 1'b1;
                    end else begin
                        write_en_r  <= 1'b1;
                        write_col_r <= col_r;
                        write_row_r <= sel_height_s;
                        write_val_r <= cell_code(player_r);
                    end
                end
                WRITE: begin
                    for (int c = 0; c < COLS; c++) begin
                        if ((col_r == 3'(c)) && (height_r[c] != 3'(ROWS))) begin
                            height_r[c] <= height_r[c] + 3'd1;
                        end
                    end
                    if (move_count_r != 6'(CELLS)) begin
                        move_count_r <= move_count_r + 6'd1;
                        board_full_r <= (move_count_r == 6'(CELLS - 1));
                    end
                end
                EVAL: begin
                    if (win) begin
                        winner_r    <= cell_code(player_r);
                        game_over_r <= 1'b1;
                    end else if (move_count_r == 6'(CELLS)) begin
                        game_over_r <= 1'b1;
                    end
                end
                SWITCH: begin
                    player_r   <= ~player_r;
                    secs_r     <= 4'(TURN_SECS);
                    prescale_r <= {PW{1'b0}};
                end
                OVER: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign write_en       = write_en_r;
    assign write_col      = write_col_r;
    assign write_row      = write_row_r;
    assign write_val      = write_val_r;
    assign current_player = player_r;
    assign secs_left      = secs_r;
    assign reject         = reject_r;
    assign move_count     = move_count_r;
    assign board_full     = board_full_r;
    assign game_over      = game_over_r;
    assign winner         = winner_r;

endmodule

// File: tb/tb_connect4_turn_sequencer.sv
// Self-checking bench for connect4_turn_sequencer: directed turns plus randomized fills,
// compared against a board/turn model built from the game rules.
module tb_connect4_turn_sequencer;

    localparam int CLK_HZ    = 4;
    localparam int TURN_SECS = 3;
    localparam int ROWS      = 6;
    localparam int COLS      = 7;
    localparam int CELLS     = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_player = 1'b0;
    logic       fpga_load = 1'b0;
    logic [2:0] fpga_col = 3'd0;
    logic       ard_valid = 1'b0;
    logic [2:0] ard_col = 3'd0;
    logic       win = 1'b0;
    logic       write_en;
    logic [2:0] write_col;
    logic [2:0] write_row;
    logic [1:0] write_val;
    logic       current_player;
    logic [3:0] secs_left;
    logic       reject;
    logic [5:0] move_count;
    logic       board_full;
    logic       game_over;
    logic [1:0] winner;

    connect4_turn_sequencer #(
        .CLK_HZ(CLK_HZ), .TURN_SECS(TURN_SECS), .ROWS(ROWS), .COLS(COLS)
    ) dut (
        .clk(clk), .rst(rst), .start_player(start_player),
        .fpga_load(fpga_load), .fpga_col(fpga_col),
        .ard_valid(ard_valid), .ard_col(ard_col), .win(win),
        .write_en(write_en), .write_col(write_col), .write_row(write_row),
        .write_val(write_val), .current_player(current_player), .secs_left(secs_left),
        .reject(reject), .move_count(move_count), .board_full(board_full),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game model: column fill heights, pieces placed, whose turn, result, WAIT cycles this turn.
    int h [COLS];
    int cnt;
    int player;
    int over_m;
    int winner_m;
    int wait_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int exp_secs();
        return (wait_k / CLK_HZ >= TURN_SECS) ? 0 : TURN_SECS - wait_k / CLK_HZ;
    endfunction

    function automatic bit legal(input int c);
        return (c < COLS) && (h[c] < ROWS);
    endfunction

    function automatic int lowest_free();
        for (int c = 0; c < COLS; c++) begin
            if (h[c] < ROWS) return c;
        end
        return 0;
    endfunction

    function automatic int random_free();
        int s;
        s = $urandom_range(0, COLS - 1);
        for (int i = 0; i < COLS; i++) begin
            if (h[(s + i) % COLS] < ROWS) return (s + i) % COLS;
        end
        return 0;
    endfunction

    task automatic model_reset(input int sp);
        for (int c = 0; c < COLS; c++) h[c] = 0;
        cnt = 0; player = sp; over_m = 0; winner_m = 0; wait_k = 0;
    endtask

    task automatic do_reset(input logic sp);
        start_player = sp; fpga_load = 1'b0; ard_valid = 1'b0; win = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_write_en", write_en, 0);
        chk("rst_write_col", write_col, 0);
        chk("rst_write_row", write_row, 0);
        chk("rst_write_val", write_val, 0);
        chk("rst_player", current_player, 0);
        chk("rst_secs", secs_left, TURN_SECS);
        chk("rst_reject", reject, 0);
        chk("rst_count", move_count, 0);
        chk("rst_full", board_full, 0);
        chk("rst_over", game_over, 0);
        chk("rst_winner", winner, 0);
        tick();
        rst = 1'b1;
        tick();
        model_reset(sp);
        chk("idle_player", current_player, sp);
    endtask

    // Called at the WRITE cycle of an accepted move; follows it through EVAL and SWITCH.
    task automatic finish_move(input int col, input logic winv);
        chk("write_en", write_en, 1);
        chk("write_col", write_col, col);
        chk("write_row", write_row, h[col]);
        chk("write_val", write_val, (player != 0) ? 2 : 1);
        chk("no_reject", reject, 0);
        h[col]++;
        cnt++;
        tick();
        win = winv;
        chk("eval_count", move_count, cnt);
        chk("strobe_one_cycle", write_en, 0);
        tick();
        win = 1'b0;
        if (winv) begin
            over_m = 1; winner_m = (player != 0) ? 2 : 1;
        end else if (cnt == CELLS) begin
            over_m = 1;
        end
        chk("game_over", game_over, over_m);
        chk("winner", winner, winner_m);
        chk("board_full", board_full, (cnt == CELLS) ? 1 : 0);
        if (over_m == 0) begin
            player = 1 - player;
            wait_k = 0;
            tick();
            chk("switch_player", current_player, player);
            chk("switch_secs", secs_left, TURN_SECS);
        end
    endtask

    // Move request from the current player, with an optional decoy on the other source.
    task automatic request(input int col, input logic winv);
        logic decoy;
        logic [2:0] dcol;
        decoy = 1'($urandom_range(0, 1));
        dcol  = 3'($urandom_range(0, 7));
        if (player == 0) begin
            fpga_load = 1'b1; fpga_col = 3'(col); ard_valid = decoy; ard_col = dcol;
        end else begin
            ard_valid = 1'b1; ard_col = 3'(col); fpga_load = decoy; fpga_col = dcol;
        end
        tick();
        fpga_load = 1'b0; ard_valid = 1'b0;
        wait_k++;
        tick();
        if (!legal(col)) begin
            chk("reject", reject, 1);
            chk("reject_no_write", write_en, 0);
            chk("reject_player", current_player, player);
            chk("reject_count", move_count, cnt);
            chk("reject_secs", secs_left, exp_secs());
        end else begin
            finish_move(col, winv);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int attempts;
        int rej;
        int c;

        // Game 1: Arduino starts; single move, column fill, bad column, timeout, win.
        do_reset(1'b1);
        request(3, 1'b0);
        for (int i = 0; i < ROWS; i++) request(2, 1'b0);
        request(2, 1'b0);
        request(7, 1'b0);
        request(0, 1'b0);
        request(1, 1'b0);

        // Player 0 idles: the Arduino pulse is ignored and the countdown auto-plays.
        chk("timeout_turn_player", current_player, 0);
        for (int i = 0; i <= CLK_HZ * TURN_SECS; i++) begin
            chk("countdown_secs", secs_left, TURN_SECS - i / CLK_HZ);
            chk("countdown_no_write", write_en, 0);
            chk("countdown_no_reject", reject, 0);
            if (i == 0) begin
                ard_valid = 1'b1; ard_col = 3'd4;
            end
            if (i < CLK_HZ * TURN_SECS) begin
                tick();
                ard_valid = 1'b0;
            end
        end
        tick();
        tick();
        finish_move(lowest_free(), 1'b0);

        request(5, 1'b0);
        request(6, 1'b1);
        wait_k = 1;
        for (int i = 0; i < 8; i++) begin
            fpga_load = 1'b1; fpga_col = 3'($urandom_range(0, 6));
            ard_valid = 1'b1; ard_col = 3'($urandom_range(0, 6));
            tick();
            fpga_load = 1'b0; ard_valid = 1'b0;
            chk("over_no_write", write_en, 0);
            chk("over_no_reject", reject, 0);
            chk("over_secs", secs_left, exp_secs());
            chk("over_count", move_count, cnt);
            chk("over_player", current_player, player);
            chk("over_flag", game_over, 1);
            chk("over_winner", winner, 1);
        end

        // Game 2: random fill to a full board with no winner.
        do_reset(1'($urandom_range(0, 1)));
        attempts = 0;
        rej = 0;
        while ((cnt < CELLS) && (attempts < 2000)) begin
            attempts++;
            c = $urandom_range(0, 7);
            if ((rej >= 5) || ((!legal(c)) && (cnt >= CELLS - 2))) c = random_free();
            if (legal(c)) rej = 0;
            else rej++;
            request(c, 1'b0);
        end
        chk("fill_count", move_count, CELLS);
        chk("fill_full", board_full, 1);
        chk("fill_over", game_over, 1);
        chk("fill_winner", winner, 0);

        // Game 3: reset lands in the middle of a WRITE cycle.
        do_reset(1'b1);
        request(4, 1'b0);
        fpga_load = 1'b1; fpga_col = 3'd4;
        tick();
        fpga_load = 1'b0;
        tick();
        chk("pre_rst_write_en", write_en, 1);
        chk("pre_rst_row", write_row, 1);
        start_player = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_write_en", write_en, 0);
        chk("async_count", move_count, 0);
        chk("async_row", write_row, 0);
        chk("async_secs", secs_left, TURN_SECS);
        tick();
        rst = 1'b1;
        tick();
        model_reset(0);
        chk("reload_player", current_player, 0);
        request(4, 1'b0);
        request(4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
